keypad_matrix_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 9 +
 rtl/keypad_col_sync.sv | 12 +
 rtl/keypad_matrix_scanner.sv | 89 ++++++++
 tb/tb_keypad_matrix_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared matrix geometry, scanner FSM states and the row strobe encoding
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  typedef enum logic [1:0] {IDLE, DRIVE, COMPARE, EMIT} scan_state_t;
  function automatic logic [NUM_ROWS-1:0] row_strobe(input logic [1:0] row);
    return ~(NUM_ROWS'(1) << row);
  endfunction
endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: 2-flop synchroniser for the column sense lines (clk, rst_n sync active-low, d async in, q synced out, resets to 4'hF)
module keypad_col_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] m;
  always_ff @(posedge clk)
    if (!rst_n) {q, m} <= 8'hFF;
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 key matrix scanner (row_n strobes out, col_n sense in) with debounced key_state and a valid/ready press/release event stream (evt_valid/evt_ready/evt_code/evt_press)
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] key_state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_code,
  output logic        evt_press
);
  if (SETTLE_CYCLES < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_param
    $error("keypad_matrix_scanner: SETTLE_CYCLES or DEBOUNCE_SCANS out of range");
  end
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  scan_state_t state, next;
  logic [1:0] row;
  logic [CW-1:0] cnt;
  logic [15:0] raw, prev_raw, diff, diff_nxt;
  logic [3:0] stable_cnt, new_cnt, idx, sync_q, sense;
  logic commit, fire;
  scan_state_t resume;
  keypad_col_sync u_sync (.clk(clk), .rst_n(rst_n), .d(col_n), .q(sync_q));
  assign sense = ~sync_q;
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) if (diff[i]) idx = 4'(i);
    new_cnt = raw != prev_raw ? 4'd1 : stable_cnt < DEB ? stable_cnt + 4'd1 : DEB;
    commit = new_cnt == DEB && raw != key_state;
    evt_valid = state == EMIT;
    evt_code = evt_valid ? idx : 4'd0;
    evt_press = evt_valid & key_state[idx];
    row_n = state == DRIVE ? row_strobe(row) : 4'hF;
    fire = evt_valid & evt_ready;
    diff_nxt = diff & ~(16'd1 << idx);
    resume = scan_en ? DRIVE : IDLE;
    next = state;
    case (state)
      IDLE:    next = resume;
      DRIVE:   next = !scan_en ? IDLE : (cnt == LAST && row == 2'd3) ? COMPARE : DRIVE;
      COMPARE: next = commit ? EMIT : resume;
      EMIT:    next = fire && diff_nxt == '0 ? resume : EMIT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      cnt <= '0;
      raw <= '0;
      prev_raw <= '0;
      stable_cnt <= DEB;
      key_state <= '0;
      diff <= '0;
    end else begin
      state <= next;
      if (next == DRIVE && state != DRIVE) begin
        row <= '0;
        cnt <= '0;
      end
      if (state == DRIVE) begin
        if (!scan_en) stable_cnt <= '0;
        else if (cnt == LAST) begin
          raw[{row, 2'b00} +: 4] <= sense;
          cnt <= '0;
          row <= row + 2'd1;
        end else cnt <= cnt + 1'b1;
      end
      if (state == COMPARE) begin
        stable_cnt <= new_cnt;
        if (raw != prev_raw) prev_raw <= raw;
        if (commit) begin
          key_state <= raw;
          diff <= raw ^ key_state;
        end
      end
      if (fire) diff <= diff_nxt;
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: self-checking bench with an ideal 4x4 key matrix, vector table, corner sequences and a scan-level random model
module tb_keypad_matrix_scanner;
  localparam int DEB = 3;
  logic clk = 0, rst_n = 0, scan_en = 0, ready_set = 1, rnd_ready = 0, rnd_bit = 0;
  logic evt_ready, evt_valid, evt_press;
  logic [3:0] row_n, col_n, evt_code;
  logic [15:0] key_state, keys = '0;
  int checks = 0, failures = 0;
  typedef struct {logic [3:0] code; logic press;} evt_t;
  typedef struct {logic [15:0] keys; logic [15:0] exp_state; int nevt; logic [3:0] code; logic press;} vec_t;
  evt_t obs[$], exp_q[$];
  vec_t vecs[7];
  logic [15:0] m_map = '0, m_prev = '0;
  int m_cnt = DEB;
  assign evt_ready = rnd_ready ? rnd_bit : ready_set;
  always #5 clk = ~clk;
  keypad_matrix_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .row_n(row_n), .col_n(col_n),
    .key_state(key_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_press(evt_press)
  );
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++) if (keys[r*4+c]) col_n[c] = 1'b0;
  end
  always @(negedge clk) if (rst_n && evt_valid && evt_ready) obs.push_back('{evt_code, evt_press});
  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic wait_scan_end;
    logic [3:0] last;
    bit done;
    last = row_n;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick;
      done = row_n == 4'hF && last != 4'hF;
      last = row_n;
    end
    if (!done) chk("scan_end_timeout", 32'd0, 32'd1);
  endtask
  task automatic wait_valid;
    bit done;
    done = evt_valid;
    for (int i = 0; i < 200 && !done; i++) begin
      tick;
      done = evt_valid;
    end
    if (!done) chk("evt_valid_timeout", 32'd0, 32'd1);
  endtask
  task automatic model_scan(input logic [15:0] s);
    if (s != m_prev) begin
      m_prev = s;
      m_cnt = 1;
    end else if (m_cnt < DEB) m_cnt++;
    if (m_cnt == DEB && s != m_map) begin
      for (int i = 0; i < 16; i++) if (s[i] != m_map[i]) exp_q.push_back('{4'(i), s[i]});
      m_map = s;
    end
  endtask
  initial begin
    int n, base, r;
    bit any_valid;
    logic [3:0] exp_row;
    vecs[0] = '{16'h0200, 16'h0200, 1, 4'd9, 1'b1};
    vecs[1] = '{16'h0000, 16'h0000, 1, 4'd9, 1'b0};
    vecs[2] = '{16'h8001, 16'h8001, 2, 4'd0, 1'b1};
    vecs[3] = '{16'h8003, 16'h8003, 1, 4'd1, 1'b1};
    vecs[4] = '{16'h0F00, 16'h0F00, 7, 4'd0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 12, 4'd0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 16, 4'd0, 1'b0};
    repeat (3) tick;
    chk("rst_row_n", 32'(row_n), 32'hF);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_evt_code", 32'(evt_code), 32'h0);
    chk("rst_evt_press", 32'(evt_press), 32'h0);
    rst_n = 1;
    scan_en = 1;
    any_valid = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      exp_row = (i % 17) < 16 ? ~(4'd1 << ((i % 17) / 4)) : 4'hF;
      chk($sformatf("idle_row_n_c%0d", i), 32'(row_n), 32'(exp_row));
      any_valid |= evt_valid;
    end
    chk("idle_no_event", 32'(any_valid), 32'd0);
    chk("idle_key_state", 32'(key_state), 32'd0);
    foreach (vecs[v]) begin
      n = obs.size();
      keys = vecs[v].keys;
      repeat (130) tick;
      chk($sformatf("vec%0d_state", v), 32'(key_state), 32'(vecs[v].exp_state));
      chk($sformatf("vec%0d_nevt", v), obs.size() - n, vecs[v].nevt);
      if (obs.size() > n) begin
        chk($sformatf("vec%0d_code", v), 32'(obs[n].code), 32'(vecs[v].code));
        chk($sformatf("vec%0d_press", v), 32'(obs[n].press), 32'(vecs[v].press));
      end else chk($sformatf("vec%0d_first_missing", v), 32'd0, 32'd1);
    end
    n = obs.size();
    for (int s = 0; s < 8; s++) begin
      wait_scan_end;
      keys = keys == 16'h0 ? 16'h0020 : 16'h0;
    end
    wait_scan_end;
    chk("alt_key_state", 32'(key_state), 32'd0);
    chk("alt_no_event", obs.size() - n, 0);
    keys = 16'h8001;
    ready_set = 0;
    wait_valid;
    chk("stall_key_state", 32'(key_state), 32'h8001);
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("stall_valid_c%0d", i), 32'(evt_valid), 32'd1);
      chk($sformatf("stall_code_c%0d", i), 32'(evt_code), 32'd0);
      tick;
    end
    ready_set = 1;
    chk("drain_code0", 32'({evt_valid, evt_code, evt_press}), 32'({1'b1, 4'd0, 1'b1}));
    tick;
    chk("drain_code15", 32'({evt_valid, evt_code, evt_press}), 32'({1'b1, 4'd15, 1'b1}));
    tick;
    chk("drain_done_valid", 32'(evt_valid), 32'd0);
    chk("drain_resume_row", 32'(row_n), 32'hE);
    wait_scan_end;
    keys = 16'h0;
    wait_scan_end;
    wait_scan_end;
    r = 0;
    for (int i = 0; i < 40 && row_n != 4'hD; i++) tick;
    chk("abort_at_row1", 32'(row_n), 32'hD);
    scan_en = 0;
    tick;
    chk("abort_row_n", 32'(row_n), 32'hF);
    n = obs.size();
    repeat (40) tick;
    chk("abort_key_state", 32'(key_state), 32'h8001);
    chk("abort_no_event", obs.size() - n, 0);
    scan_en = 1;
    wait_scan_end;
    wait_scan_end;
    tick;
    chk("rescan2_no_commit", 32'(key_state), 32'h8001);
    wait_scan_end;
    tick;
    chk("rescan3_commit", 32'(key_state), 32'h0);
    repeat (10) tick;
    wait_scan_end;
    keys = 16'h0011;
    ready_set = 0;
    wait_valid;
    rst_n = 0;
    tick;
    chk("midrst_evt_valid", 32'(evt_valid), 32'd0);
    chk("midrst_key_state", 32'(key_state), 32'd0);
    chk("midrst_row_n", 32'(row_n), 32'hF);
    rst_n = 1;
    ready_set = 1;
    keys = 16'h0;
    n = obs.size();
    repeat (60) tick;
    chk("midrst_no_residual", obs.size() - n, 0);
    wait_scan_end;
    base = obs.size();
    keys = 16'($urandom);
    rnd_ready = 1;
    for (int s = 0; s < 44; s++) begin
      wait_scan_end;
      chk($sformatf("rnd_state_s%0d", s), 32'(key_state), 32'(m_map));
      model_scan(keys);
      if (s < 40) begin
        r = $urandom_range(0, 9);
        if (r >= 9) keys = 16'($urandom);
        else if (r >= 6) keys = keys ^ (16'd1 << $urandom_range(0, 15));
      end
    end
    repeat (80) tick;
    rnd_ready = 0;
    chk("rnd_count", obs.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++)
      chk($sformatf("rnd_evt%0d", i), 32'({obs[base+i].code, obs[base+i].press}),
          32'({exp_q[i].code, exp_q[i].press}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
